// File: rtl/cdc_level_sync.sv
// Multi-flop level synchronizer bringing slow asynchronous control levels into the i_clk domain,
// with optional single-cycle rising/falling edge strobes decoded from the synchronized level.
module cdc_level_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2,
    parameter bit          R      = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_pe,
    output logic [WIDTH-1:0] o_ne
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("cdc_level_sync: STAGES must be in the range 2..4");
    end

    localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{R}};

    // Stage 0 may go metastable; the attributes keep the chain packed, unmerged and unretimed.
    (* ASYNC_REG = "TRUE", keep = "true", dont_touch = "true" *)
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sync_d    = sync_q;
        hist_d    = sync_q[STAGES-1];
        sync_d[0] = i_d;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_d[k] = RST_VAL;
            end
            hist_d = RST_VAL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        sync_q <= sync_d;
        hist_q <= hist_d;
    end

    // Level and history both reset to R, so neither reset entry nor exit can decode a strobe.
    assign o_q  = sync_q[STAGES-1];
    assign o_pe = sync_q[STAGES-1] & ~hist_q;
    assign o_ne = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: tb/tb_cdc_level_sync.sv
// Self-checking bench: four cdc_level_sync variants share stimulus and are compared each cycle
// against a history-based model of what each output must be after every clock edge.
module tb_cdc_level_sync;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_d   = 4'hF;

    logic [3:0] q0, pe0, ne0;   // STAGES=2, R=0
    logic [3:0] q1, pe1, ne1;   // STAGES=3, R=0
    logic [3:0] q2, pe2, ne2;   // STAGES=2, R=1
    logic [3:0] q3, pe3, ne3;   // STAGES=4, R=1

    cdc_level_sync #(.WIDTH(4), .STAGES(2), .R(1'b0)) dut_s2r0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .o_q(q0), .o_pe(pe0), .o_ne(ne0));
    cdc_level_sync #(.WIDTH(4), .STAGES(3), .R(1'b0)) dut_s3r0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .o_q(q1), .o_pe(pe1), .o_ne(ne1));
    cdc_level_sync #(.WIDTH(4), .STAGES(2), .R(1'b1)) dut_s2r1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .o_q(q2), .o_pe(pe2), .o_ne(ne2));
    cdc_level_sync #(.WIDTH(4), .STAGES(4), .R(1'b1)) dut_s4r1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .o_q(q3), .o_pe(pe3), .o_ne(ne3));

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Inputs as sampled at each rising edge, indexed by edge number.
    logic [3:0] d_hist[$];
    bit         rst_hist[$];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", tag, obs, exp, d_hist.size() - 1);
        end
    endtask

    // Level after edge t: the input seen s-1 edges earlier, unless any of the last s edges was a reset.
    function automatic logic [3:0] model_q(int s, bit r, int t);
        if (t - s + 1 < 0) return {4{r}};
        for (int j = t - s + 1; j <= t; j++) begin
            if (rst_hist[j]) return {4{r}};
        end
        return d_hist[t - s + 1];
    endfunction

    // Level one edge earlier, or R if edge t itself was a reset.
    function automatic logic [3:0] model_hist(int s, bit r, int t);
        if (t < 0 || rst_hist[t]) return {4{r}};
        return model_q(s, r, t - 1);
    endfunction

    task automatic check_dut(input string pre, input int s, input bit r,
                             input logic [3:0] q, input logic [3:0] pe, input logic [3:0] ne);
        int t;
        logic [3:0] eq, eh;
        t  = d_hist.size() - 1;
        eq = model_q(s, r, t);
        eh = model_hist(s, r, t);
        check({pre, "_q"},  q,  eq);
        check({pre, "_pe"}, pe, eq & ~eh);
        check({pre, "_ne"}, ne, ~eq & eh);
        check({pre, "_excl"}, pe & ne, 4'b0000);
    endtask

    // One clock: apply inputs, let the edge happen, record what was sampled, then check outputs.
    task automatic step(input logic [3:0] d, input logic rst);
        i_d   = d;
        i_rst = rst;
        @(posedge i_clk);
        d_hist.push_back(d);
        rst_hist.push_back(rst);
        #1;
        check_dut("s2r0", 2, 1'b0, q0, pe0, ne0);
        check_dut("s3r0", 3, 1'b0, q1, pe1, ne1);
        check_dut("s2r1", 2, 1'b1, q2, pe2, ne2);
        check_dut("s4r1", 4, 1'b1, q3, pe3, ne3);
    endtask

    initial begin
        int pe_cnt, ne_cnt;

        // Reset with i_d high, then release: R=0 copies rise once, R=1 copies stay quiet.
        repeat (3) step(4'hF, 1'b1);
        check("rst_r0_q", q0, 4'h0);
        check("rst_r1_q", q2, 4'hF);
        step(4'hF, 1'b0);
        check("rel_r0_q_early", q0, 4'h0);
        step(4'hF, 1'b0);
        check("rel_r0_q", q0, 4'hF);
        check("rel_r0_pe", pe0, 4'hF);
        check("rel_r1_pe", pe2, 4'h0);
        step(4'hF, 1'b0);
        check("rel_r0_pe_once", pe0, 4'h0);
        repeat (3) step(4'hF, 1'b0);

        // Drop to 0 for a while, then a long high pulse: exactly one strobe of each kind.
        repeat (5) step(4'h0, 1'b0);
        pe_cnt = 0;
        ne_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'h1, 1'b0);
            pe_cnt += int'(pe0[0]);
            ne_cnt += int'(ne0[0]);
        end
        for (int i = 0; i < 10; i++) begin
            step(4'h0, 1'b0);
            pe_cnt += int'(pe0[0]);
            ne_cnt += int'(ne0[0]);
        end
        check("lat_pe_count", 4'(pe_cnt), 4'd1);
        check("lat_ne_count", 4'(ne_cnt), 4'd1);

        // Toggle every cycle.
        for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 4'hF : 4'h0, 1'b0);

        // Reset arriving while the rising level is still inside the chain.
        repeat (4) step(4'h0, 1'b0);
        step(4'hF, 1'b0);
        step(4'hF, 1'b1);
        check("mid_rst_q", q0, 4'h0);
        check("mid_rst_pe", pe0, 4'h0);
        step(4'hF, 1'b1);
        repeat (6) step(4'hF, 1'b0);

        // Multi-bit independence.
        repeat (4) step(4'h0, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        check("wide_pe_0101", pe0, 4'b0101);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        check("wide_pe_1010", pe0, 4'b1010);
        check("wide_ne_0101", ne0, 4'b0101);
        repeat (3) step(4'b1010, 1'b0);

        // Random levels, held for random lengths, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] d;
            d = 4'($urandom);
            repeat ($urandom_range(1, 4)) step(d, ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_level_sync.md
Name: cdc_level_sync

Overview:
- Multi-flop clock-domain-crossing synchronizer for slow, level-type control signals (e.g. SPI chip-select and transaction-done flags) entering the i_clk system domain.
- Outputs the synchronized level with a configurable reset value.
- Optionally outputs single-cycle rising-edge and falling-edge strobes derived from the synchronized level.
- Replaces the separate plain and edge-detecting synchronizers with one parameterized block.

Parameters:
- WIDTH, 1: number of independent bits synchronized in parallel; each bit is handled identically.
- STAGES, 2: synchronizer flop depth, legal range 2..4.
- R, 0: reset value (0 or 1) of every synchronizer stage, of the history flop and hence of o_q. Applies to all bits.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_d  input  WIDTH  asynchronous input level (foreign clock domain).
- o_q  output  WIDTH  synchronized level.
- o_pe  output  WIDTH  rising-edge strobe of o_q, one cycle.
- o_ne  output  WIDTH  falling-edge strobe of o_q, one cycle.

Behaviour:
- Reset (reset i_rst, synchronous, active-high; clock i_clk):
  - On a rising i_clk edge with i_rst=1, all STAGES flops and the history flop load R.
  - After reset, o_q=R, o_pe=0 and o_ne=0.
  - No spurious edge is ever reported on reset entry or exit.
- Chain:
  - stage[0] <= i_d, and stage[k] <= stage[k-1] on each rising edge when i_rst=0.
  - o_q = stage[STAGES-1], driven directly from a register with no combinational path from i_d.
- Latency:
  - An i_d change that is stable before rising edge N appears on o_q after edge N+STAGES-1. With STAGES=2, that is after the 2nd edge.
  - Metastable capture may add one further cycle. This is acceptable.
- Edge strobes:
  - The history flop is hist <= o_q each cycle, and resets to R.
  - o_pe = o_q & ~hist; o_ne = ~o_q & hist.
  - o_pe is high for exactly the first cycle in which o_q is 1 after having been 0; o_ne is the mirror case.
  - o_pe and o_ne are never high together on the same bit.
  - Both are glitch-free because they are decoded only from registers.
- Input pulses:
  - An i_d pulse shorter than one i_clk period may be lost. This is allowed; the source must hold levels for at least 2 i_clk periods to be guaranteed seen.
  - A held level yields exactly one strobe per transition.
  - A toggle every cycle, with i_d stable at each edge, produces alternating o_pe/o_ne pulses every cycle, delayed by STAGES.
- Reset mid-operation:
  - Asserting i_rst discards in-flight values; all outputs return to reset values on the next edge.
  - On release with i_d != R, o_q changes STAGES cycles later and produces one strobe.
- Multi-bit:
  - Bits are independent.
  - No coherency is guaranteed across bits; the block must not be used for multi-bit buses that require coherency.
- Synthesis attributes:
  - Stage flops carry the toolchain's ASYNC_REG / keep attribute.
  - Stage flops must not be merged, retimed or replicated.

Test Plan:
- Reset, R=0: i_rst=1 for 3 cycles with i_d=1, then release. Required: o_q=0, o_pe=0 and o_ne=0 during reset. o_q=1 exactly 2 cycles after release, o_pe=1 in that cycle only, o_ne stays 0.
- Reset, R=1: i_rst=1 with i_d=1, then release and hold i_d=1. Required: o_q=1 throughout, with no o_pe or o_ne pulse. Next, drive i_d=0 for 5 cycles. Required: o_q=0 after 2 edges and a single o_ne pulse.
- Latency and strobe width: i_d 0->1 held for 10 cycles, then 1->0. Required: o_pe is high for exactly 1 cycle, 2 edges after the rise. o_ne is high for exactly 1 cycle, 2 edges after the fall. No other strobes occur.
- Toggle: i_d alternates every cycle, 1010..., with STAGES=2. Required: o_q reproduces the pattern delayed by 2 cycles, and o_pe and o_ne alternate every cycle. STAGES=3 gives a 3-cycle delay.
- Reset mid-transition: i_d rises, then i_rst=1 one edge later, while stage[0]=1 and o_q=0. Required: o_q=0 and no o_pe during reset. After release with i_d=1 held, one o_pe occurs 2 cycles later.
- WIDTH=4: i_d=4'b0101 then 4'b1010. Required: o_pe=4'b0101 for one cycle; one cycle after the change is synchronized, o_pe=4'b1010 and o_ne=4'b0101 in the same cycle.
